seq_restoring_div: RTL

Sequential restoring divider: inverse companion to the 4x4 Vedic multiplier in the same Tiny Tapeout design. It divides an 8-bit unsigned dividend by a 4-bit unsigned divisor. It produces one quotient bit per clock. Operands enter and results leave through valid/ready handshakes, so the block can sit between the `ui_in` operand capture and the `uo_out` register.

---
 rtl/seq_restoring_div.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional result self-check is compiled in with `define DIV_SELFCHECK_EN.
module seq_restoring_div #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          chk_err
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           w_in_ready;
  logic           w_out_valid;
  logic [DW-1:0]  r_q;
  logic [VW-1:0]  r_r;
  logic [VW-1:0]  r_d;
  logic [CW-1:0]  r_cnt;
  logic           r_dbz;
  logic           w_accept;
  logic           w_last;
  logic [VW:0]    w_t;
  logic           w_ge;
  logic [VW-1:0]  w_r_step;
  logic [DW-1:0]  w_q_step;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = w_out_valid;
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_CALC) && (r_cnt == '0);

  // One restoring step; the partial remainder stays below D so VW bits hold it
  assign w_t      = {r_r, r_q[DW-1]};
  assign w_ge     = (w_t >= {1'b0, r_d});
  assign w_r_step = w_ge ? VW'(w_t - {1'b0, r_d}) : w_t[VW-1:0];
  assign w_q_step = (r_q << 1) | DW'(w_ge);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_d   <= divisor;
      r_cnt <= CW'(DW - 1);
      r_dbz <= (divisor == '0);
      if (divisor == '0) begin
        r_q <= '1;
        r_r <= dividend[VW-1:0];
      end else begin
        r_q <= dividend;
        r_r <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_q <= w_q_step;
      r_r <= w_r_step;
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

`ifdef DIV_SELFCHECK_EN
  localparam int unsigned PW = DW + VW;

  logic [DW-1:0] r_dvd;
  logic [PW-1:0] w_recon;
  logic          w_chk;
  logic          r_chk;

  // Reconstruct the dividend from the result about to be presented
  assign w_recon = (PW'(w_q_step) * PW'(r_d)) + PW'(w_r_step);
  assign w_chk   = (w_recon != PW'(r_dvd)) || (w_r_step >= r_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_chk <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= dividend;
      r_chk <= 1'b0;
    end else if (w_last) begin
      r_chk <= w_chk;
    end else if ((r_state == S_DONE) && out_ready) begin
      r_chk <= 1'b0;
    end
  end

  assign chk_err = r_chk;
`else
  assign chk_err = 1'b0;
`endif

endmodule
